// File: rtl/mem_pkg.sv
// Shared encodings for the data-memory access path: sizes, exception codes,
// FSM states and the cause numbers the exception handler reports.
package mem_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  localparam logic [1:0] EXC_NONE    = 2'b00;
  localparam logic [1:0] EXC_LD_MIS  = 2'b01;
  localparam logic [1:0] EXC_ST_MIS  = 2'b10;
  localparam logic [1:0] EXC_TIMEOUT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_RESP = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  // Cause numbers the exception handler records for data-memory faults.
  localparam logic [3:0] DM_CAUSE_LD_MIS   = 4'd4;
  localparam logic [3:0] DM_CAUSE_LD_FAULT = 4'd5;
  localparam logic [3:0] DM_CAUSE_ST_MIS   = 4'd6;
  localparam logic [3:0] DM_CAUSE_ST_FAULT = 4'd7;

  function automatic logic [3:0] dm_cause(input logic [1:0] code, input logic we);
    case (code)
      EXC_LD_MIS:  dm_cause = DM_CAUSE_LD_MIS;
      EXC_ST_MIS:  dm_cause = DM_CAUSE_ST_MIS;
      EXC_TIMEOUT: dm_cause = we ? DM_CAUSE_ST_FAULT : DM_CAUSE_LD_FAULT;
      default:     dm_cause = 4'd0;
    endcase
  endfunction

  // Size 11 falls into the default arm and is treated as a word.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = addr_lo[0];
      default: is_misaligned = |addr_lo;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Byte-lane steering for the data bus: store enables/replication, alignment
// check and load lane extraction with sign or zero extension.
module lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        misaligned_o,
  output logic [31:0] ld_data_o
);

  logic [7:0]  lane [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane[gi] = rdata_i[8*gi +: 8];
  end

  assign byte_sel     = lane[addr_lo_i];
  assign half_sel     = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  assign misaligned_o = is_misaligned(size_i, addr_lo_i);

  always_comb begin
    be_o      = 4'b1111;
    wdata_o   = wdata_i;
    ld_data_o = rdata_i;
    case (size_i)
      SZ_BYTE: begin
        be_o      = 4'b0001 << addr_lo_i;
        wdata_o   = {4{wdata_i[7:0]}};
        ld_data_o = {{24{signed_i & byte_sel[7]}}, byte_sel};
      end
      SZ_HALF: begin
        be_o      = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o   = {2{wdata_i[15:0]}};
        ld_data_o = {{16{signed_i & half_sel[15]}}, half_sel};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator: one op at a time on the req/gnt/rvalid
// data bus, stalling the pipeline until the access completes or faults.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic        op_we,
  input  logic [1:0]  op_size,
  input  logic        op_signed,
  input  logic [31:0] op_addr,
  input  logic [31:0] op_wdata,
  input  logic [31:0] op_pc,
  output logic        stall,
  output logic        ld_valid,
  output logic [31:0] ld_data,
  output logic        exc_valid,
  output logic [1:0]  exc_code,
  output logic [31:0] exc_addr,
  output logic [31:0] exc_pc,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q;
  logic [15:0] cnt_q, cnt_d;
  logic        we_q, signed_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, pc_q;
  logic        mem_req_q, mem_we_q;
  logic [31:0] mem_addr_q, mem_wdata_q;
  logic [3:0]  mem_be_q;
  logic        ld_valid_q, exc_valid_q;
  logic [31:0] ld_data_q, exc_addr_q, exc_pc_q;
  logic [1:0]  exc_code_q;

  logic        in_idle, cnt_expired;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_ld_data;
  logic        al_misaligned;

  // In IDLE the aligner looks at the incoming op; afterwards at the latched one.
  assign in_idle     = (state_q == ST_IDLE);
  assign cnt_d       = cnt_q + 16'd1;
  assign cnt_expired = (cnt_q == CNT_LAST);

  lane_align u_align (
    .size_i       (in_idle ? op_size : size_q),
    .signed_i     (in_idle ? op_signed : signed_q),
    .addr_lo_i    (in_idle ? op_addr[1:0] : addr_q[1:0]),
    .wdata_i      (op_wdata),
    .rdata_i      (mem_rdata),
    .be_o         (al_be),
    .wdata_o      (al_wdata),
    .misaligned_o (al_misaligned),
    .ld_data_o    (al_ld_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 16'd0;
      we_q        <= 1'b0;
      signed_q    <= 1'b0;
      size_q      <= SZ_WORD;
      addr_q      <= 32'd0;
      pc_q        <= 32'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_be_q    <= 4'd0;
      mem_wdata_q <= 32'd0;
      ld_valid_q  <= 1'b0;
      ld_data_q   <= 32'd0;
      exc_valid_q <= 1'b0;
      exc_code_q  <= EXC_NONE;
      exc_addr_q  <= 32'd0;
      exc_pc_q    <= 32'd0;
    end else begin
      ld_valid_q  <= 1'b0;
      exc_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (op_valid) begin
            we_q     <= op_we;
            size_q   <= op_size;
            signed_q <= op_signed;
            addr_q   <= op_addr;
            pc_q     <= op_pc;
            if (al_misaligned) begin
              state_q     <= ST_DONE;
              exc_valid_q <= 1'b1;
              exc_code_q  <= op_we ? EXC_ST_MIS : EXC_LD_MIS;
              exc_addr_q  <= op_addr;
              exc_pc_q    <= op_pc;
            end else begin
              state_q     <= ST_REQ;
              cnt_q       <= 16'd0;
              mem_req_q   <= 1'b1;
              mem_we_q    <= op_we;
              mem_addr_q  <= {op_addr[31:2], 2'b00};
              mem_be_q    <= al_be;
              mem_wdata_q <= al_wdata;
            end
          end
        end
        ST_REQ: begin
          if (mem_gnt) begin
            state_q   <= ST_RESP;
            mem_req_q <= 1'b0;
            cnt_q     <= cnt_d;
          end else if (cnt_expired) begin
            state_q     <= ST_DONE;
            mem_req_q   <= 1'b0;
            exc_valid_q <= 1'b1;
            exc_code_q  <= EXC_TIMEOUT;
            exc_addr_q  <= addr_q;
            exc_pc_q    <= pc_q;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ST_RESP: begin
          if (mem_rvalid) begin
            state_q <= ST_DONE;
            if (!we_q) begin
              ld_valid_q <= 1'b1;
              ld_data_q  <= al_ld_data;
            end
          end else if (cnt_expired) begin
            state_q     <= ST_DONE;
            exc_valid_q <= 1'b1;
            exc_code_q  <= EXC_TIMEOUT;
            exc_addr_q  <= addr_q;
            exc_pc_q    <= pc_q;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign stall     = (in_idle & op_valid) | (state_q == ST_REQ) | (state_q == ST_RESP);
  assign ld_valid  = ld_valid_q;
  assign ld_data   = ld_data_q;
  assign exc_valid = exc_valid_q;
  assign exc_code  = exc_code_q;
  assign exc_addr  = exc_addr_q;
  assign exc_pc    = exc_pc_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator in the CPU MEM stage. Takes one load or store per pipeline op, issues it on the word-wide data-memory bus with a req/gnt/rvalid handshake, and stalls the pipeline until the bus responds. Stores are byte-lane steered; loads are extracted and sign- or zero-extended. Misaligned accesses and bus timeouts are reported as exceptions.

## Interface
- TIMEOUT_CYCLES, 255: max cycles spent in REQ+RESP before abort (1..65535)
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- op_valid  in  1  MEM stage holds a load/store
- op_we  in  1  1 = store, 0 = load
- op_size  in  2  00 word, 01 half, 10 byte, 11 treated as word
- op_signed  in  1  load extension: 1 sign, 0 zero
- op_addr  in  32  byte address
- op_wdata  in  32  store data, right-justified
- op_pc  in  32  PC of the op, latched for exception report
- stall  out  1  freeze pipeline
- ld_valid  out  1  load data valid (DONE cycle only)
- ld_data  out  32  extended load result
- exc_valid  out  1  exception pulse (DONE cycle only)
- exc_code  out  2  01 load misaligned, 10 store misaligned, 11 bus timeout
- exc_addr  out  32  faulting byte address; exc_pc out 32 faulting PC
- mem_req, mem_we  out  1  request / write
- mem_addr  out  32  {addr[31:2],2'b00}
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_gnt, mem_rvalid  in  1  grant / response (also the write ack)
- mem_rdata  in  32  read word

## Operation
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE with op_valid: latch op fields. If aligned, go to REQ. If misaligned, go to DONE with an exception and no bus activity.
- Misaligned cases: half with addr[0]=1; word or size 11 with addr[1:0]≠0.
- REQ: mem_req=1 with all mem_* outputs stable. On mem_gnt, go to RESP.
- RESP: wait for mem_rvalid. Then go to DONE; for a load, register the extracted data.
- DONE: for a load, ld_valid=1; or exc_valid=1. Always return to IDLE on the next cycle.
- Timeout: a 16-bit counter clears on entering REQ and counts each REQ/RESP cycle. Reaching TIMEOUT_CYCLES drops mem_req and goes to DONE with exc_code 11. A late rvalid after abort is ignored in IDLE.
- Byte enables:
  - byte: 4'b0001<<addr[1:0]
  - half: addr[1] ? 1100 : 0011
  - word: 1111
- Store data: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word as-is.
- Load data: select lane by addr[1:0] (byte) or addr[1] (half); extend to 32 bits per op_signed. Word loads ignore op_signed.
- stall = (IDLE & op_valid) | REQ | RESP. stall is 0 in DONE, so the pipeline advances at the end of DONE.
- Stores complete silently; ld_valid is never raised for stores.

## Timing
- Reset: state IDLE, counter 0. All outputs 0 on the cycle after the reset edge, including stall, mem_req, ld_valid, exc_valid, ld_data, exc_*.
- Reset mid-transaction: abandon it immediately. No exception and no ld_valid.
- Minimum aligned latency: 4 cycles (IDLE, REQ with gnt, RESP with rvalid, DONE).
- Misaligned latency: 2 cycles (IDLE, DONE).
- mem_rvalid is never asserted in the same cycle as the corresponding mem_gnt. The bus guarantees this; the block need not handle it.
- op_valid low in IDLE: no state change, stall=0.
- ld_data holds its value after DONE until the next load completes. exc_* outputs hold until the next exception.

## Structure
- Shared package mem_pkg holds:
  - size encodings SZ_WORD/SZ_HALF/SZ_BYTE
  - exception codes EXC_LD_MIS/EXC_ST_MIS/EXC_TIMEOUT
  - the state enum
  - DM exception code constants shared with the exception handler
- One combinational sub-module, lane_align. It generates be, store replication, misalignment flag, and load extraction/extension from size, signed, and addr[1:0]. The top level holds the FSM, timeout counter, and registers.

## Test plan
- Word store to 0x0000_1004, data 0xDEADBEEF, gnt and rvalid one cycle apart -> mem_addr 0x1004, be 1111, wdata 0xDEADBEEF; stall high for 3 cycles; no ld_valid.
- Byte store 0xAB to 0x1003 -> be 1000, wdata 0xABABABAB. Half store 0x1234 to 0x1002 -> be 1100, wdata 0x12341234.
- Loads with rdata 0x80FF7F01:
  - signed byte at 0x...1 -> 0x0000007F
  - signed byte at 0x...2 -> 0xFFFFFFFF
  - unsigned half at 0x...2 -> 0x000080FF
  - signed half at 0x...2 -> 0xFFFF80FF
- Half load at 0x1001 -> no mem_req, exc_valid in cycle 2 with code 01, exc_addr 0x1001, exc_pc latched. Word store at 0x1002 -> code 10.
- TIMEOUT_CYCLES=8, gnt never asserted -> mem_req high for 8 cycles then drops; exc_code 11. A later op proceeds normally.
- reset asserted while in RESP -> next cycle IDLE, all outputs 0; a subsequent load completes with correct data.
